// File: rtl/irq_pending_latch_pkg.sv
// Shared widths, mask reset value and service FSM encoding for the
// interrupt pending latch that feeds the 16-to-4 priority encoder.
package irq_pending_latch_pkg;

   localparam int NUM_REQ = 16;
   localparam int IDX_W   = 4;

   localparam logic [NUM_REQ-1:0] MASK_RST = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OFFER   = 2'd1,
      ST_SERVICE = 2'd2
   } svc_state_t;

   function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/irq_pending_latch_sync_edge.sv
// Two-flop synchroniser for the raw request lines followed by a
// rising-edge detector on the synchronised value.
module req_sync_edge #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_in,
   output logic [N-1:0] rise
);

   logic [N-1:0] s1;
   logic [N-1:0] s2;
   logic [N-1:0] prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
      end else begin
         s1   <= req_in;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign rise = s2 & ~prev;

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky, maskable pending-request latch that drives the priority encoder
// and runs the irq/ack/done service handshake on the encoder's winner.
module irq_pending_latch
   import irq_pending_latch_pkg::*;
#(
   parameter int N    = NUM_REQ,
   parameter int IDXW = IDX_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_in,
   input  logic            mask_we,
   input  logic [N-1:0]    mask_in,
   output logic [N-1:0]    mask,
   output logic [N-1:0]    pend,
   input  logic [IDXW-1:0] enc_idx,
   input  logic            enc_valid,
   output logic            irq,
   output logic [IDXW-1:0] svc_idx,
   output logic            svc_valid,
   input  logic            ack,
   input  logic            done
);

   logic [N-1:0] rise;
   logic [N-1:0] pending;
   logic [N-1:0] clr_vec;
   logic         take_ack;
   svc_state_t   state;

   req_sync_edge #(.N(N)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_in (req_in),
      .rise   (rise)
   );

   // A masked-off offer is withdrawn before ack is even considered.
   assign take_ack = (state == ST_OFFER) && mask[svc_idx] && ack;
   assign clr_vec  = take_ack ? idx_onehot(svc_idx) : '0;
   assign pend     = pending & mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         mask    <= MASK_RST;
      end else begin
         pending <= (pending & ~clr_vec) | rise;
         if (mask_we) begin
            mask <= mask_in;
         end
      end
   end

   // enc_idx is sampled only under enc_valid, so an undriven index never lands in svc_idx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         irq       <= 1'b0;
         svc_idx   <= '0;
         svc_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enc_valid) begin
                  state   <= ST_OFFER;
                  svc_idx <= enc_idx;
                  irq     <= 1'b1;
               end
            end
            ST_OFFER: begin
               if (!mask[svc_idx]) begin
                  state <= ST_IDLE;
                  irq   <= 1'b0;
               end else if (ack) begin
                  state     <= ST_SERVICE;
                  irq       <= 1'b0;
                  svc_valid <= 1'b1;
               end
            end
            ST_SERVICE: begin
               if (done) begin
                  state     <= ST_IDLE;
                  svc_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               irq       <= 1'b0;
               svc_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Randomised and directed bench for irq_pending_latch against a
// request-history reference model with a behavioural priority encoder.
module tb_irq_pending_latch;

   logic        clk;
   logic        rst_n;
   logic [15:0] req_in;
   logic        mask_we;
   logic [15:0] mask_in;
   logic [15:0] mask;
   logic [15:0] pend;
   logic [3:0]  enc_idx;
   logic        enc_valid;
   logic        irq;
   logic [3:0]  svc_idx;
   logic        svc_valid;
   logic        ack;
   logic        done;

   int assertCount = 0;
   int failCount   = 0;

   logic [15:0] mPending;
   logic [15:0] mMask;
   bit          mOffer;
   bit          mService;
   logic [3:0]  mIdx;
   logic [15:0] reqHist[$];

   irq_pending_latch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (req_in),
      .mask_we   (mask_we),
      .mask_in   (mask_in),
      .mask      (mask),
      .pend      (pend),
      .enc_idx   (enc_idx),
      .enc_valid (enc_valid),
      .irq       (irq),
      .svc_idx   (svc_idx),
      .svc_valid (svc_valid),
      .ack       (ack),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Highest-index-wins encoder; index is left undefined when nothing is pending.
   always_comb begin
      enc_valid = |pend;
      enc_idx   = 4'bxxxx;
      for (int i = 0; i < 16; i++) begin
         if (pend[i]) enc_idx = 4'(i);
      end
   end

   function automatic logic [3:0] highestSet(input logic [15:0] v);
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) return 4'(i);
      end
      return 4'd0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel();
      mPending = '0;
      mMask    = 16'hFFFF;
      mOffer   = 0;
      mService = 0;
      mIdx     = '0;
      reqHist  = {16'h0, 16'h0, 16'h0};
   endtask

   // One clock edge of the reference: a line is newly pending when it was
   // seen high two edges ago and low three edges ago.
   task automatic modelEdge();
      logic [15:0] riseVec;
      logic [15:0] clrVec;
      logic [15:0] visible;
      riseVec = reqHist[1] & ~reqHist[2];
      clrVec  = '0;
      visible = mPending & mMask;
      if (mOffer) begin
         if (!mMask[mIdx]) begin
            mOffer = 0;
         end else if (ack) begin
            clrVec   = 16'h1 << mIdx;
            mOffer   = 0;
            mService = 1;
         end
      end else if (mService) begin
         if (done) mService = 0;
      end else if (visible != 0) begin
         mOffer = 1;
         mIdx   = highestSet(visible);
      end
      mPending = (mPending & ~clrVec) | riseVec;
      if (mask_we) mMask = mask_in;
      reqHist.push_front(req_in);
      void'(reqHist.pop_back());
   endtask

   task automatic compareAll();
      checkOutput("pend", pend, mPending & mMask);
      checkOutput("mask", mask, mMask);
      checkOutput("irq", irq, mOffer);
      checkOutput("svc_valid", svc_valid, mService);
      checkOutput("svc_idx", svc_idx, mIdx);
   endtask

   task automatic applyStimulus(input logic [15:0] r, input logic mwe,
                                input logic [15:0] mi, input logic a, input logic d);
      @(negedge clk);
      req_in  = r;
      mask_we = mwe;
      mask_in = mi;
      ack     = a;
      done    = d;
      modelEdge();
      @(posedge clk);
      #1;
      compareAll();
   endtask

   task automatic idleSteps(input logic [15:0] r, input int n);
      for (int k = 0; k < n; k++) applyStimulus(r, 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n   = 1'b0;
      req_in  = 16'hFFFF;
      mask_we = 1'b0;
      mask_in = 16'h0;
      ack     = 1'b0;
      done    = 1'b0;
      resetModel();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_pend", pend, 16'h0);
      checkOutput("rst_mask", mask, 16'hFFFF);
      checkOutput("rst_irq", irq, 1'b0);
      checkOutput("rst_svc_valid", svc_valid, 1'b0);
      @(negedge clk);
      req_in = 16'h0;
      rst_n  = 1'b1;
      idleSteps(16'h0, 20);

      // single line and its latency
      idleSteps(16'h0020, 3);
      checkOutput("lat_pend_e3", pend, 16'h0020);
      checkOutput("lat_irq_e3", irq, 1'b0);
      idleSteps(16'h0020, 1);
      checkOutput("lat_irq_e4", irq, 1'b1);
      checkOutput("lat_idx_e4", svc_idx, 4'd5);
      applyStimulus(16'h0020, 1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("ack_pend", pend, 16'h0);
      checkOutput("ack_svc_valid", svc_valid, 1'b1);
      applyStimulus(16'h0020, 1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("done_svc_valid", svc_valid, 1'b0);
      idleSteps(16'h0, 3);

      // two lines, then a higher line arriving during the offer
      idleSteps(16'h1008, 4);
      checkOutput("two_idx", svc_idx, 4'd12);
      idleSteps(16'h5008, 4);
      checkOutput("frozen_idx", svc_idx, 4'd12);
      applyStimulus(16'h5008, 1'b0, 16'h0, 1'b1, 1'b0);
      applyStimulus(16'h5008, 1'b0, 16'h0, 1'b0, 1'b1);
      idleSteps(16'h5008, 1);
      checkOutput("next_idx14", svc_idx, 4'd14);
      checkOutput("next_irq14", irq, 1'b1);
      applyStimulus(16'h5008, 1'b0, 16'h0, 1'b1, 1'b0);
      applyStimulus(16'h5008, 1'b0, 16'h0, 1'b0, 1'b1);
      idleSteps(16'h5008, 1);
      checkOutput("next_idx3", svc_idx, 4'd3);
      applyStimulus(16'h5008, 1'b0, 16'h0, 1'b1, 1'b0);
      applyStimulus(16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      idleSteps(16'h0, 3);

      // mask withdraw during offer, then re-expose
      idleSteps(16'h0080, 4);
      checkOutput("mw_idx", svc_idx, 4'd7);
      applyStimulus(16'h0080, 1'b1, 16'hFF7F, 1'b0, 1'b0);
      applyStimulus(16'h0080, 1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("mw_irq", irq, 1'b0);
      checkOutput("mw_svc_valid", svc_valid, 1'b0);
      applyStimulus(16'h0080, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      checkOutput("unmask_pend", pend, 16'h0080);
      idleSteps(16'h0080, 1);
      checkOutput("reoffer_idx", svc_idx, 4'd7);
      checkOutput("reoffer_irq", irq, 1'b1);
      applyStimulus(16'h0080, 1'b0, 16'h0, 1'b1, 1'b0);
      applyStimulus(16'h0080, 1'b0, 16'h0, 1'b0, 1'b1);
      idleSteps(16'h0080, 2);

      // re-rise of line 9 landing on its own ack edge
      idleSteps(16'h0280, 4);
      checkOutput("sw_idx", svc_idx, 4'd9);
      idleSteps(16'h0080, 1);
      idleSteps(16'h0280, 2);
      applyStimulus(16'h0280, 1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("sw_pend9", pend[9], 1'b1);
      checkOutput("sw_svc_valid", svc_valid, 1'b1);
      applyStimulus(16'h0280, 1'b0, 16'h0, 1'b0, 1'b1);
      idleSteps(16'h0280, 1);
      checkOutput("sw_reoffer_irq", irq, 1'b1);
      checkOutput("sw_reoffer_idx", svc_idx, 4'd9);
      applyStimulus(16'h0280, 1'b0, 16'h0, 1'b1, 1'b0);
      applyStimulus(16'h0280, 1'b0, 16'h0, 1'b0, 1'b1);
      idleSteps(16'h0280, 2);

      // reset while line 2 is in service
      idleSteps(16'h0284, 4);
      checkOutput("mr_idx", svc_idx, 4'd2);
      applyStimulus(16'h0284, 1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("mr_svc_valid", svc_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mr_irq", irq, 1'b0);
      checkOutput("mr_svc_valid_rst", svc_valid, 1'b0);
      checkOutput("mr_svc_idx", svc_idx, 4'd0);
      checkOutput("mr_pend", pend, 16'h0);
      checkOutput("mr_mask", mask, 16'hFFFF);
      req_in = 16'h0;
      ack    = 1'b0;
      resetModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idleSteps(16'h0, 20);

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         logic [15:0] r;
         logic        mwe;
         logic [15:0] mi;
         r   = req_in ^ 16'($urandom & $urandom & $urandom);
         mwe = ($urandom_range(0, 15) == 0);
         mi  = 16'($urandom | $urandom);
         applyStimulus(r, mwe, mi, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream stage of the 16-to-4 priority encoder. Owns the encoder's 16-bit request vector and consumes its index/valid result.
- Synchronises 16 raw request lines, edge-detects them and holds sticky pending bits, masked by a software-writable mask.
- Drives the masked pending vector into the encoder, captures the encoder's winning index and runs an irq/ack/done service handshake that clears the serviced bit.

Parameters:
- N, 16, number of request lines; must equal the encoder input width.
- IDXW, 4, index width; must equal log2(N).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_in  input  N  raw request lines, asynchronous to clk, level.
- mask_we  input  1  write strobe for the mask register.
- mask_in  input  N  new mask value; 1 = line enabled.
- mask  output  N  current mask register.
- pend  output  N  pending & mask; connects to encoder input w.
- enc_idx  input  IDXW  encoder index output y; meaningful only when enc_valid=1.
- enc_valid  input  1  encoder z output; 1 = pend nonzero.
- irq  output  1  interrupt to the consumer.
- svc_idx  output  IDXW  index being offered or serviced.
- svc_valid  output  1  service in progress.
- ack  input  1  consumer accepts the offered interrupt.
- done  input  1  consumer has finished servicing.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync/prev flops=0, pending=0, mask=16'hFFFF.
  - state=IDLE, irq=0, svc_idx=0, svc_valid=0.
- Synchroniser: two flops s1←req_in, s2←s1, then prev←s2. rise = s2 & ~prev.
- Pending update each edge: pending_next = (pending & ~clr_vec) | rise.
  - clr_vec is one-hot of svc_idx on the ack cycle, otherwise 0.
  - Set wins over clear on the same bit in the same cycle.
- Pending captures regardless of mask; pend = pending & mask (combinational).
- Latency: req_in rise before edge 1 → pending bit set at edge 3 → pend visible after edge 3 → irq=1 after edge 4.
- mask_we=1: mask←mask_in at that edge. Masking never clears pending; unmasking re-exposes held bits.
- enc_idx is ignored when enc_valid=0. X on enc_idx must not propagate into any register.
- FSM (registered outputs):
  - IDLE: irq=0, svc_valid=0. If enc_valid → OFFER, svc_idx←enc_idx, irq←1.
  - OFFER: irq=1, svc_idx frozen; later encoder changes (higher index arrives) are ignored.
    - If mask[svc_idx]=0 (masked before ack) → IDLE, irq←0. Pending bit is retained; this check has priority over ack.
    - Else if ack → SERVICE: clear pending[svc_idx] (subject to set-wins), irq←0, svc_valid←1.
  - SERVICE: svc_valid=1, svc_idx held. ack is ignored. On done → IDLE, svc_valid←0.
  - done in IDLE or OFFER is ignored.
- Minimum one IDLE cycle between services, so back-to-back interrupts are spaced ≥2 cycles at irq.
- Re-rise of the line being serviced during SERVICE sets pending again; it is offered after return to IDLE.
- Priority is the encoder's (highest index); this block adds no arbitration.
- Reset asserted mid-operation: immediate return to reset values; in-flight service is abandoned and pending is lost.

Decomposition:
- Shared package: N, IDXW, mask reset value 16'hFFFF, FSM state encoding (IDLE=2'd0, OFFER=2'd1, SERVICE=2'd2; 2'd3 unreachable, recovers to IDLE).
- One natural sub-module: req_sync_edge (N-wide two-flop synchroniser + rise detector, output rise[N-1:0]). FSM and pending register stay in the top.

Test Plan:
- Reset, then idle: hold rst_n=0 with req_in=16'hFFFF, release with req_in=0 → pend=0, irq=0, mask=16'hFFFF, no irq for 20 cycles.
- Single line + latency: req_in[5] rises, encoder model returns 5 → pend=16'h0020 after edge 3, irq=1 and svc_idx=5 after edge 4. ack → pend=0, svc_valid=1. done → IDLE.
- Two lines + frozen index: req_in[3] and req_in[12] rise together → svc_idx=12.
  - req_in[14] rising during OFFER leaves svc_idx at 12.
  - ack, done → next offer is svc_idx=14, then svc_idx=3.
- Mask withdraw: pending on line 7, mask_we with mask_in=16'hFF7F during OFFER → irq=0, IDLE, pending[7] still 1.
  - Unmask (16'hFFFF) → line 7 re-offered with svc_idx=7.
- Set-wins collision: line 9 re-rises so its rise lands on the ack cycle of svc_idx=9 → pending[9] stays 1. After done, irq re-asserts with svc_idx=9.
- Reset mid-service: in SERVICE with svc_idx=2, pulse rst_n=0 → all outputs return to reset values asynchronously; no irq until a new rise.
